// File: rtl/pll_sup_pkg.sv
// rtl/pll_sup_pkg.sv - shared state encoding and counter sizing for the PLL lock supervisor
package pll_sup_pkg;

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAULT
    } pll_sup_state_e;

    // Bits needed for a counter that must be able to hold max_val itself.
    function automatic int cnt_w(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// rtl/pll_lock_sync.sv - two-flop synchronizer for an asynchronous PLL lock indication
module pll_lock_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset sequencing, lock qualification, timeout retry and fault
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RESET_HOLD_CYCLES   = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 16000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                               referenceclk,
    input  logic                               reset,
    input  logic                               pll_lock,
    input  logic                               fault_clear,
    output logic                               pll_resetb,
    output logic                               sys_resetn,
    output logic                               locked,
    output logic                               fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count
);

    localparam int HW = cnt_w(RESET_HOLD_CYCLES);
    localparam int TW = cnt_w(LOCK_TIMEOUT_CYCLES);
    localparam int SW = cnt_w(LOCK_STABLE_CYCLES);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TMO_MAX   = TW'(LOCK_TIMEOUT_CYCLES);
    localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    pll_sup_state_e  state, state_nxt;
    logic [HW-1:0]   hold_cnt, hold_nxt;
    logic [TW-1:0]   tmo_cnt, tmo_nxt, tmo_inc;
    logic [SW-1:0]   stab_cnt, stab_nxt;
    logic [RW-1:0]   retry_nxt;
    logic            lock_s;
    logic            timeout;

    pll_lock_sync u_lock_sync (
        .clk   (referenceclk),
        .rst_n (reset),
        .d     (pll_lock),
        .q     (lock_s)
    );

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        tmo_nxt   = tmo_cnt;
        stab_nxt  = stab_cnt;
        retry_nxt = retry_count;
        tmo_inc   = (tmo_cnt == TMO_MAX) ? tmo_cnt : tmo_cnt + 1'b1;
        timeout   = (tmo_inc == TMO_MAX);

        case (state)
            ST_HOLD: begin
                if (hold_cnt >= HOLD_LAST) begin
                    state_nxt = ST_WAIT_LOCK;
                    hold_nxt  = '0;
                    tmo_nxt   = '0;
                    stab_nxt  = '0;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            ST_WAIT_LOCK, ST_STABLE: begin
                tmo_nxt = tmo_inc;
                // The timeout check comes first so a lock qualifying on the
                // deadline cycle still counts as a failed attempt.
                if (timeout) begin
                    retry_nxt = (retry_count == RETRY_MAX) ? retry_count : retry_count + 1'b1;
                    state_nxt = (retry_nxt == RETRY_MAX) ? ST_FAULT : ST_HOLD;
                    stab_nxt  = '0;
                end else if (state == ST_WAIT_LOCK) begin
                    if (lock_s) begin
                        state_nxt = ST_STABLE;
                        stab_nxt  = '0;
                    end
                end else if (!lock_s) begin
                    state_nxt = ST_WAIT_LOCK;
                    stab_nxt  = '0;
                end else if (stab_cnt >= STAB_LAST) begin
                    state_nxt = ST_RUN;
                end else begin
                    stab_nxt = stab_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_nxt = ST_HOLD;
                    retry_nxt = '0;
                end
            end
            ST_FAULT: begin
                if (fault_clear) begin
                    state_nxt = ST_HOLD;
                    retry_nxt = '0;
                end
            end
            default: state_nxt = ST_HOLD;
        endcase
    end

    // Outputs are decoded from the next state so they move on the same edge as the state.
    always_ff @(posedge referenceclk or negedge reset) begin
        if (!reset) begin
            state       <= ST_HOLD;
            hold_cnt    <= '0;
            tmo_cnt     <= '0;
            stab_cnt    <= '0;
            retry_count <= '0;
            pll_resetb  <= 1'b0;
            sys_resetn  <= 1'b0;
            locked      <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_nxt;
            hold_cnt    <= hold_nxt;
            tmo_cnt     <= tmo_nxt;
            stab_cnt    <= stab_nxt;
            retry_count <= retry_nxt;
            pll_resetb  <= (state_nxt == ST_WAIT_LOCK) || (state_nxt == ST_STABLE) ||
                           (state_nxt == ST_RUN);
            sys_resetn  <= (state_nxt == ST_RUN);
            locked      <= (state_nxt == ST_RUN);
            fault       <= (state_nxt == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - scoreboard bench for pll_lock_supervisor
module tb_pll_lock_supervisor;

    localparam int H  = 4;
    localparam int T  = 64;
    localparam int S  = 8;
    localparam int M  = 2;
    localparam int RW = $clog2(M + 1);

    localparam int PH_HOLD  = 0;
    localparam int PH_TRY   = 1;
    localparam int PH_RUN   = 2;
    localparam int PH_FAULT = 3;

    localparam int SEL_RESETB = 0;
    localparam int SEL_LOCKED = 1;
    localparam int SEL_FAULT  = 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic          pll_lock = 1'b0;
    logic          fault_clear = 1'b0;
    logic          pll_resetb, sys_resetn, locked, fault;
    logic [RW-1:0] retry_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int            edge_no;
        logic [RW+3:0] vec;
    } exp_t;

    exp_t          sbq[$];
    bit            lh[$];
    bit            in_reset = 1'b1;
    int            n = 0;
    int            phase = PH_HOLD;
    int            rel_at = H;
    int            r = 0;
    int            retries = 0;
    logic [RW+3:0] exp_last = '0;
    logic [RW+3:0] mon_prev = '0;
    logic [RW+3:0] v, cur;
    bit            win;
    exp_t          e, en;
    int            t_lock, t_fall;

    pll_lock_supervisor #(
        .RESET_HOLD_CYCLES   (H),
        .LOCK_TIMEOUT_CYCLES (T),
        .LOCK_STABLE_CYCLES  (S),
        .MAX_RETRIES         (M)
    ) dut (
        .referenceclk (clk),
        .reset        (resetn),
        .pll_lock     (pll_lock),
        .fault_clear  (fault_clear),
        .pll_resetb   (pll_resetb),
        .sys_resetn   (sys_resetn),
        .locked       (locked),
        .fault        (fault),
        .retry_count  (retry_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, req, n);
        end
    endtask

    // Synchronized lock as the supervisor sees it when deciding at edge m.
    function automatic bit ls(input int m);
        int j = m - 2;
        if (j < 1) return 1'b0;
        return lh[j-1];
    endfunction

    function automatic logic sig(input int sel);
        case (sel)
            SEL_RESETB: return pll_resetb;
            SEL_LOCKED: return locked;
            default:    return fault;
        endcase
    endfunction

    // Reference model: attempt deadlines and a sliding window of S+1 lock samples.
    initial forever begin
        @(posedge clk);
        if (!in_reset) begin
            n++;
            lh.push_back(pll_lock);
            case (phase)
                PH_HOLD: if (n == rel_at) begin phase = PH_TRY; r = n; end
                PH_TRY: begin
                    if (n == r + T) begin
                        retries++;
                        if (retries == M) phase = PH_FAULT;
                        else begin phase = PH_HOLD; rel_at = n + H; end
                    end else if (n - S >= r + 1) begin
                        win = 1'b1;
                        for (int k = 0; k <= S; k++) if (!ls(n - k)) win = 1'b0;
                        if (win) phase = PH_RUN;
                    end
                end
                PH_RUN: if (!ls(n)) begin phase = PH_HOLD; rel_at = n + H; retries = 0; end
                default: if (fault_clear) begin phase = PH_HOLD; rel_at = n + H; retries = 0; end
            endcase
            v = {(phase == PH_TRY) || (phase == PH_RUN), phase == PH_RUN, phase == PH_RUN,
                 phase == PH_FAULT, RW'(retries)};
            if (v != exp_last) begin
                en.edge_no = n;
                en.vec     = v;
                sbq.push_back(en);
                exp_last = v;
            end
        end
    end

    // Monitor: every change of the output vector must match the next expected event.
    initial forever begin
        @(negedge clk);
        if (!in_reset) begin
            cur = {pll_resetb, sys_resetn, locked, fault, retry_count};
            if (cur !== mon_prev) begin
                check("sb_event_pending", 32'(sbq.size() != 0), 32'd1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    check("out_edge", n, e.edge_no);
                    check("out_vec", 32'(cur), 32'(e.vec));
                end
                mon_prev = cur;
            end else if (sbq.size() != 0 && sbq[0].edge_no <= n) begin
                e = sbq.pop_front();
                check("missed_change", 32'(cur), 32'(e.vec));
            end
        end
    end

    task automatic wait_sig(input int sel, input logic val, input int lim, input string nm,
                            input bit clr);
        int k = 0;
        while (sig(sel) !== val && k < lim) begin
            @(negedge clk);
            k++;
            fault_clear = clr && (fault === 1'b1);
        end
        fault_clear = 1'b0;
        check(nm, 32'(sig(sel)), 32'(val));
    endtask

    task automatic do_reset(input bit mid);
        if (mid) begin
            @(posedge clk);
            #2;
        end
        in_reset = 1'b1;
        resetn   = 1'b0;
        #1;
        check("rst_pll_resetb", 32'(pll_resetb), 0);
        check("rst_sys_resetn", 32'(sys_resetn), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_retry", 32'(retry_count), 0);
        pll_lock    = 1'b0;
        fault_clear = 1'b0;
        repeat (3) @(negedge clk);
        sbq.delete();
        lh.delete();
        n        = 0;
        phase    = PH_HOLD;
        rel_at   = H;
        r        = 0;
        retries  = 0;
        exp_last = '0;
        mon_prev = '0;
        resetn   = 1'b1;
        in_reset = 1'b0;
    endtask

    task automatic relock_cycle(input int dly, input string nm);
        pll_lock = 1'b0;
        wait_sig(SEL_RESETB, 1'b0, 2*T + 40, {nm, "_fall"}, 1'b1);
        wait_sig(SEL_RESETB, 1'b1, 2*T + 40, {nm, "_rise"}, 1'b1);
        repeat (dly) @(negedge clk);
        pll_lock = 1'b1;
        t_lock   = n + 1;
    endtask

    initial begin
        do_reset(1'b0);

        // clean lock, with a stray fault_clear that must be ignored
        wait_sig(SEL_RESETB, 1'b1, 50, "first_rise", 1'b0);
        check("first_release_edge", n, H);
        fault_clear = 1'b1;
        @(negedge clk);
        fault_clear = 1'b0;
        repeat (8) @(negedge clk);
        pll_lock = 1'b1;
        t_lock   = n + 1;
        wait_sig(SEL_LOCKED, 1'b1, 40, "clean_locked", 1'b0);
        check("clean_run_edge", n, t_lock + 2 + S);
        check("clean_retry", 32'(retry_count), 0);

        // lock loss in RUN and hold pulse width
        repeat (5) @(negedge clk);
        pll_lock = 1'b0;
        t_lock   = n + 1;
        wait_sig(SEL_RESETB, 1'b0, 10, "loss_fall", 1'b0);
        check("loss_edge", n, t_lock + 2);
        check("loss_sys_resetn", 32'(sys_resetn), 0);
        t_fall = n;
        wait_sig(SEL_RESETB, 1'b1, 20, "loss_rise", 1'b0);
        check("hold_width", n - t_fall, H);
        repeat ($urandom_range(0, 20)) @(negedge clk);
        pll_lock = 1'b1;
        t_lock   = n + 1;
        wait_sig(SEL_LOCKED, 1'b1, 40, "relock", 1'b0);
        check("relock_edge", n, t_lock + 2 + S);
        check("relock_retry", 32'(retry_count), 0);

        // glitch while qualifying
        relock_cycle(3, "glitch");
        repeat (5) @(negedge clk);
        pll_lock = 1'b0;
        repeat (2) @(negedge clk);
        pll_lock = 1'b1;
        t_lock   = n + 1;
        wait_sig(SEL_LOCKED, 1'b1, 40, "glitch_locked", 1'b0);
        check("glitch_run_edge", n, t_lock + 2 + S);
        check("glitch_retry", 32'(retry_count), 0);

        // stable count completes on the timeout cycle: timeout wins
        pll_lock = 1'b0;
        wait_sig(SEL_RESETB, 1'b0, 20, "coll_fall", 1'b0);
        wait_sig(SEL_RESETB, 1'b1, 20, "coll_rise", 1'b0);
        t_fall = n;
        repeat (T - S - 3) @(negedge clk);
        pll_lock = 1'b1;
        wait_sig(SEL_RESETB, 1'b0, T, "coll_timeout", 1'b0);
        check("coll_edge", n, t_fall + T);
        check("coll_retry", 32'(retry_count), 1);
        check("coll_not_locked", 32'(locked), 0);
        wait_sig(SEL_LOCKED, 1'b1, 40, "coll_then_run", 1'b0);
        check("run_keeps_retry", 32'(retry_count), 1);

        // two timeouts reach FAULT, then clear
        pll_lock = 1'b0;
        wait_sig(SEL_FAULT, 1'b1, 2*(T + H) + 20, "fault_set", 1'b0);
        check("fault_retry", 32'(retry_count), M);
        check("fault_pll_resetb", 32'(pll_resetb), 0);
        check("fault_sys_resetn", 32'(sys_resetn), 0);
        repeat ($urandom_range(1, 5)) @(negedge clk);
        fault_clear = 1'b1;
        @(negedge clk);
        fault_clear = 1'b0;
        check("fault_cleared", 32'(fault), 0);
        check("clear_retry", 32'(retry_count), 0);

        // random lock waveforms
        for (int it = 0; it < 25; it++) begin
            int nseg;
            relock_cycle($urandom_range(0, 70), "rnd");
            nseg = $urandom_range(1, 6);
            for (int s = 0; s < nseg; s++) begin
                pll_lock = 1'($urandom_range(0, 1));
                repeat ($urandom_range(1, 25)) @(negedge clk);
            end
        end

        // asynchronous reset while running
        relock_cycle(2, "pre_rst");
        wait_sig(SEL_LOCKED, 1'b1, 40, "pre_rst_locked", 1'b0);
        do_reset(1'b1);
        wait_sig(SEL_RESETB, 1'b1, 50, "post_rst_rise", 1'b0);
        check("post_rst_release_edge", n, H);
        pll_lock = 1'b1;
        t_lock   = n + 1;
        wait_sig(SEL_LOCKED, 1'b1, 40, "post_rst_locked", 1'b0);
        check("post_rst_run_edge", n, t_lock + 2 + S);

        repeat (3) @(negedge clk);
        check("sb_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Lock supervisor and reset sequencer for the SB_PLL40_CORE clock generators on the test board. Drives the PLL's active-low RESETB, watches its asynchronous LOCK output, and releases a system reset to downstream logic only after lock has held for a programmable time. Runs on the PLL reference clock because the PLL output is not trustworthy until lock. Retries the PLL on lock timeout and raises a sticky fault after a bounded number of attempts.

## Interface
- RESET_HOLD_CYCLES, 16: cycles PLL_RESETB is held low per attempt (≥1)
- LOCK_TIMEOUT_CYCLES, 16000: max cycles from PLL release to qualified lock (1 ms at 16 MHz)
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before RUN; must be < LOCK_TIMEOUT_CYCLES
- MAX_RETRIES, 3: failed attempts before FAULT (≥1)
- REFERENCECLK  in  1  sole clock, PLL reference
- RESET  in  1  asynchronous, active-low block reset
- PLL_LOCK  in  1  PLL LOCK, asynchronous to REFERENCECLK
- FAULT_CLEAR  in  1  single-cycle pulse; leaves FAULT and restarts sequence
- PLL_RESETB  out  1  to PLL RESETB, active-low
- SYS_RESETN  out  1  downstream reset, active-low
- LOCKED  out  1  high only in RUN
- FAULT  out  1  high only in FAULT
- RETRY_COUNT  out  $clog2(MAX_RETRIES+1)  failed attempts in current sequence

## Operation
- PLL_LOCK passes a 2-flop synchronizer (flops reset to 0) → lock_s. All decisions use lock_s.
- States: HOLD, WAIT_LOCK, STABLE, RUN, FAULT. Reset state HOLD.
- HOLD: PLL_RESETB=0. hold_cnt counts to RESET_HOLD_CYCLES, then → WAIT_LOCK; tmo_cnt and stab_cnt cleared on exit.
- WAIT_LOCK: PLL_RESETB=1, tmo_cnt increments. lock_s=1 → STABLE (stab_cnt=0).
- STABLE: tmo_cnt keeps incrementing, stab_cnt increments while lock_s=1. lock_s=0 → WAIT_LOCK (stab_cnt cleared, tmo_cnt not cleared). stab_cnt reaches LOCK_STABLE_CYCLES → RUN.
- Timeout: tmo_cnt reaches LOCK_TIMEOUT_CYCLES in WAIT_LOCK or STABLE → RETRY_COUNT+1; if new value == MAX_RETRIES → FAULT, else → HOLD. Timeout has priority over STABLE→RUN on the same cycle.
- RUN: PLL_RESETB=1, SYS_RESETN=1, LOCKED=1. lock_s=0 for one cycle → HOLD with RETRY_COUNT cleared (lock loss after success starts a fresh sequence).
- FAULT: PLL_RESETB=0, SYS_RESETN=0, FAULT=1; RETRY_COUNT holds MAX_RETRIES. FAULT_CLEAR → HOLD, RETRY_COUNT=0. FAULT_CLEAR ignored in all other states.
- SYS_RESETN=0 in every state except RUN.
- Counters saturate; no wrap.

## Timing
- Reset (RESET low, async): state HOLD, PLL_RESETB=0, SYS_RESETN=0, LOCKED=0, FAULT=0, RETRY_COUNT=0, counters and synchronizer 0. RESET asserted mid-RUN drops SYS_RESETN immediately (asynchronously).
- All outputs registered, decoded from next state: they change on the same edge as the state register.
- PLL_RESETB low for exactly RESET_HOLD_CYCLES cycles per attempt.
- PLL_LOCK rises before edge t → lock_s high after edge t+1 → STABLE at edge t+2 → RUN/SYS_RESETN=1 at edge t+2+LOCK_STABLE_CYCLES.
- Lock loss in RUN: PLL_LOCK falls before edge t → SYS_RESETN=0, LOCKED=0, PLL_RESETB=0 at edge t+2.
- Lock pulses shorter than one cycle may be missed; no requirement to detect them.

## Structure
- Shared package pll_sup_pkg: state enum (HOLD, WAIT_LOCK, STABLE, RUN, FAULT) and counter-width helper function.
- One sub-module: pll_lock_sync (2-flop synchronizer, async active-low reset to 0), reusable for other PLL wrappers.

## Test plan
Bench parameters: RESET_HOLD_CYCLES=4, LOCK_TIMEOUT_CYCLES=64, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.
- Clean lock: model raises PLL_LOCK 10 cycles after PLL_RESETB rises → PLL_RESETB low exactly 4 cycles; SYS_RESETN=1, LOCKED=1 exactly 2+8 cycles after lock; RETRY_COUNT=0.
- Lock glitch in STABLE: lock high 5 cycles, low 2, then high → re-enters WAIT_LOCK, RUN reached 8 stable cycles after final rise, no retry.
- Timeout retries: PLL_LOCK never rises → 64-cycle timeout, RETRY_COUNT=1, new 4-cycle PLL_RESETB pulse; second timeout → FAULT=1, RETRY_COUNT=2, PLL_RESETB=0; FAULT_CLEAR pulse → HOLD, RETRY_COUNT=0.
- Lock loss in RUN: drop PLL_LOCK → SYS_RESETN=0 and PLL_RESETB=0 two edges later; relock → RUN again with RETRY_COUNT=0.
- Timeout vs. stable collision: lock rises so stab_cnt hits 8 on the timeout cycle → timeout wins, RETRY_COUNT increments, no RUN.
- Async reset mid-RUN: RESET low between edges → SYS_RESETN, LOCKED low immediately; after release sequence restarts from HOLD.
